// File: rtl/router_egress_pkg.sv
// Shared types and constants for the router egress scheduler.
package router_egress_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int NUM_PORTS    = 3;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Sideband that travels with every byte from read issue to the egress link.
  typedef struct packed {
    logic [1:0] port;
    logic       sop;
    logic       eop;
    logic       perr;
  } tag_t;

  // Round-robin successor over the three ports.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_egress_skid.sv
// Small circular FIFO of {tag, byte} entries feeding the egress link.
// The head entry is visible combinationally; count is registered.
module router_egress_skid
  import router_egress_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output tag_t          head_tag,
  output logic [7:0]    head_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          tag_mem  [DEPTH];
  logic [7:0]    data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/router_egress_arb.sv
// Round-robin egress scheduler: drains whole packets from three router
// output FIFOs onto one 8-bit valid/ready link without interleaving.
// Optional feature macro: PARITY_CHECK_EN (packet parity check -> egress_perr).
//
// Handshake: a beat transfers on a cycle where egress_valid and egress_ready
// are both high; egress_valid never depends on egress_ready and the beat is
// held stable while valid is high and ready is low. FIFO reads are issued on
// credit (skid occupancy + in-flight byte) so egress_ready never reaches
// read_enb_N combinationally.
module router_egress_arb
  import router_egress_pkg::*;
#(
  parameter int SKID_DEPTH = 3,
  parameter int STALL_MAX  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       egress_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] egress_data,
  output logic       egress_valid,
  output logic       egress_sop,
  output logic       egress_eop,
  output logic [1:0] egress_port,
  output logic       pkt_abort,
  output logic       egress_perr
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  state_t        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [6:0]    remaining_q, remaining_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          inflight_q;
  tag_t          inflight_tag_q;
  logic [2:0]    vld;
  logic [CW-1:0] skid_count;
  logic          credit;
  logic          rd_any;
  tag_t          rd_tag;
  logic [1:0]    arb_grant;
  logic          arb_found;
  logic [1:0]    cand;
  logic [7:0]    in_data;
  logic          perr_c;
  tag_t          push_tag;
  tag_t          head_tag;
  logic [7:0]    head_data;

  assign vld    = {vld_out_2, vld_out_1, vld_out_0};
  assign credit = (32'(skid_count) + 32'(inflight_q)) < 32'(SKID_DEPTH);

  // Round-robin search starting at rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!arb_found && vld[cand]) begin
        arb_found = 1'b1;
        arb_grant = cand;
      end
      cand = next_port(cand);
    end
  end

  // Byte returning from the FIFO that was read last cycle.
  always_comb begin
    in_data = 8'h00;
    case (inflight_tag_q.port)
      2'd0:    in_data = data_out_0;
      2'd1:    in_data = data_out_1;
      2'd2:    in_data = data_out_2;
      default: in_data = 8'h00;
    endcase
  end

  // Packet FSM: next state, read issue and tag generation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    rd_any      = 1'b0;
    rd_tag      = '0;
    case (state_q)
      ARB: begin
        if (arb_found && credit) begin
          rd_any      = 1'b1;
          rd_tag.port = arb_grant;
          rd_tag.sop  = 1'b1;
          grant_d     = arb_grant;
          state_d     = HDR;
        end
      end
      HDR: begin
        // Header byte is arriving now; count payload plus the parity byte.
        remaining_d = {1'b0, in_data[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
        stall_d     = '0;
        state_d     = BODY;
      end
      BODY: begin
        if (vld[grant_q]) begin
          stall_d = '0;
          if (credit) begin
            rd_any      = 1'b1;
            rd_tag.port = grant_q;
            rd_tag.eop  = (remaining_q == 7'd1);
            remaining_d = remaining_q - 7'd1;
            if (remaining_q == 7'd1) begin
              rr_ptr_d = next_port(grant_q);
              state_d  = ARB;
            end
          end
        end else if (stall_q == SW'(STALL_MAX - 1)) begin
          state_d = ABORT;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      ABORT: begin
        rr_ptr_d = next_port(grant_q);
        state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // FSM and in-flight stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARB;
      rr_ptr_q       <= 2'd0;
      grant_q        <= 2'd0;
      remaining_q    <= '0;
      stall_q        <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      remaining_q    <= remaining_d;
      stall_q        <= stall_d;
      inflight_q     <= rd_any;
      inflight_tag_q <= rd_tag;
    end
  end

`ifdef PARITY_CHECK_EN
  logic [7:0] xor_q;

  // Running XOR of header and payload, reseeded on every header byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= 8'h00;
    end else if (inflight_q) begin
      xor_q <= inflight_tag_q.sop ? in_data : (xor_q ^ in_data);
    end
  end

  assign perr_c = inflight_tag_q.eop && (xor_q != in_data);
`else
  assign perr_c = 1'b0;
`endif

  always_comb begin
    push_tag      = inflight_tag_q;
    push_tag.perr = inflight_tag_q.perr | perr_c;
  end

  router_egress_skid #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_tag  (push_tag),
    .push_data (in_data),
    .pop       (egress_valid & egress_ready),
    .head_tag  (head_tag),
    .head_data (head_data),
    .count     (skid_count)
  );

  // Reads are masked during reset so every output is low while rst is high.
  assign read_enb_0   = rd_any & ~rst & (rd_tag.port == 2'd0);
  assign read_enb_1   = rd_any & ~rst & (rd_tag.port == 2'd1);
  assign read_enb_2   = rd_any & ~rst & (rd_tag.port == 2'd2);
  assign pkt_abort    = (state_q == ABORT);
  assign egress_valid = (skid_count != '0);
  assign egress_data  = egress_valid ? head_data : 8'h00;
  assign egress_sop   = egress_valid & head_tag.sop;
  assign egress_eop   = egress_valid & head_tag.eop;
  assign egress_port  = egress_valid ? head_tag.port : 2'd0;
  assign egress_perr  = egress_valid & head_tag.perr;

endmodule

// File: tb/tb_router_egress_arb.sv
// Bench for router_egress_arb: FIFO models per port, packet-level reference
// model for round-robin order and parity, expected-beat scoreboard.
`timescale 1ns/1ps
module tb_router_egress_arb;

  localparam int SKID_DEPTH = 3;
  localparam int STALL_MAX  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
  logic       egress_ready = 1'b0;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] egress_data;
  logic       egress_valid, egress_sop, egress_eop, egress_perr, pkt_abort;
  logic [1:0] egress_port;

  router_egress_arb #(.SKID_DEPTH(SKID_DEPTH), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .egress_ready(egress_ready),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .egress_data(egress_data), .egress_valid(egress_valid),
    .egress_sop(egress_sop), .egress_eop(egress_eop), .egress_port(egress_port),
    .pkt_abort(pkt_abort), .egress_perr(egress_perr)
  );

  // ---------------- state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  fq0[$], fq1[$], fq2[$];   // router FIFO contents
  logic [7:0]  mq0[$], mq1[$], mq2[$];   // same bytes, consumed by the model
  logic [12:0] exp_q[$];                 // {port, sop, eop, perr, data}
  logic [1:0]  sop_q[$];
  int          pkt_cnt[3];
  int          rd_cnt[3];
  int          model_ptr   = 0;
  int          outstanding = 0;
  int          beat_cnt    = 0;
  int          abort_cnt   = 0;
  int          ready_low   = 0;
  bit          rdy_mode    = 1'b0;
  bit          prev_stall  = 1'b0;
  logic [12:0] prev_beat   = '0;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- FIFO / model helpers ----------------
  function automatic void update_vld();
    vld_out_0 = (fq0.size() > 0);
    vld_out_1 = (fq1.size() > 0);
    vld_out_2 = (fq2.size() > 0);
  endfunction

  function automatic void push_byte(input int p, input logic [7:0] b);
    if (p == 0)      begin fq0.push_back(b); mq0.push_back(b); end
    else if (p == 1) begin fq1.push_back(b); mq1.push_back(b); end
    else             begin fq2.push_back(b); mq2.push_back(b); end
  endfunction

  function automatic logic [7:0] mq_pop(input int p);
    if (p == 0) return mq0.pop_front();
    if (p == 1) return mq1.pop_front();
    return mq2.pop_front();
  endfunction

  function automatic logic [12:0] mk_beat(input int p, input bit sop, input bit eop,
                                          input bit perr, input logic [7:0] d);
    logic [1:0] pp;
    pp = 2'(p);
    return {pp, sop, eop, perr, d};
  endfunction

  // One packet: header {len, port}, random payload, parity (optionally corrupted).
  task automatic load_pkt(input int p, input int len, input bit corrupt);
    logic [7:0] hdr, acc, b;
    logic [5:0] l6;
    logic [1:0] pp;
    l6 = 6'(len);
    pp = 2'(p);
    hdr = {l6, pp};
    acc = hdr;
    push_byte(p, hdr);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      acc ^= b;
      push_byte(p, b);
    end
    if (corrupt) acc ^= 8'($urandom_range(1, 255));
    push_byte(p, acc);
    pkt_cnt[p]++;
  endtask

  // Reference model: serve loaded packets in round-robin order, whole packets.
  task automatic plan();
    while (pkt_cnt[0] + pkt_cnt[1] + pkt_cnt[2] > 0) begin
      int p;
      int len;
      logic [7:0] hdr, acc, b, par;
      bit perr;
      p = -1;
      for (int i = 0; i < 3; i++) begin
        int c;
        c = (model_ptr + i) % 3;
        if (p < 0 && pkt_cnt[c] > 0) p = c;
      end
      pkt_cnt[p]--;
      hdr = mq_pop(p);
      len = int'(hdr) / 4;
      acc = hdr;
      exp_q.push_back(mk_beat(p, 1'b1, 1'b0, 1'b0, hdr));
      for (int k = 0; k < len; k++) begin
        b = mq_pop(p);
        acc ^= b;
        exp_q.push_back(mk_beat(p, 1'b0, 1'b0, 1'b0, b));
      end
      par = mq_pop(p);
`ifdef PARITY_CHECK_EN
      perr = (acc != par);
`else
      perr = 1'b0;
`endif
      exp_q.push_back(mk_beat(p, 1'b0, 1'b1, perr, par));
      model_ptr = (p + 1) % 3;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic [2:0]  re;
    logic [12:0] beat;
    logic        hs;
    if (ready_low > 0) begin
      egress_ready = 1'b0;
      ready_low--;
    end else if (rdy_mode) begin
      egress_ready = ($urandom_range(0, 9) < 7);
    end else begin
      egress_ready = 1'b1;
    end
    #1;
    re   = {read_enb_2, read_enb_1, read_enb_0};
    beat = {egress_port, egress_sop, egress_eop, egress_perr, egress_data};
    hs   = egress_valid && egress_ready;
    check_eq("read_onehot", 32'($countones(re) <= 1), 1);
    check_eq("credit_bound", 32'(outstanding + $countones(re) <= SKID_DEPTH), 1);
    if (prev_stall) check_eq("hold_beat", {egress_valid, beat}, {1'b1, prev_beat});
    if (hs) begin
      check_eq("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("beat", beat, exp_q.pop_front());
      if (egress_sop) sop_q.push_back(egress_port);
      beat_cnt++;
    end
    if (pkt_abort) abort_cnt++;
    for (int i = 0; i < 3; i++) if (re[i]) rd_cnt[i]++;
    outstanding += $countones(re) - int'(hs);
    prev_stall = egress_valid && !egress_ready;
    prev_beat  = beat;
    @(posedge clk);
    #1;
    if (re[0] && fq0.size() > 0) data_out_0 = fq0.pop_front();
    if (re[1] && fq1.size() > 0) data_out_1 = fq1.pop_front();
    if (re[2] && fq2.size() > 0) data_out_2 = fq2.pop_front();
    update_vld();
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0 || outstanding > 0) && cyc < budget) begin
      tick();
      cyc++;
    end
    check_eq("drain_exp_left", exp_q.size(), 0);
    check_eq("drain_outstanding", outstanding, 0);
  endtask

  // Asynchronous reset pulse: outputs must drop without waiting for a clock.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq(tag, {read_enb_0, read_enb_1, read_enb_2, egress_valid, egress_data,
                   egress_sop, egress_eop, egress_port, pkt_abort, egress_perr}, 0);
    fq0.delete(); fq1.delete(); fq2.delete();
    mq0.delete(); mq1.delete(); mq2.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) pkt_cnt[i] = 0;
    model_ptr   = 0;
    outstanding = 0;
    prev_stall  = 1'b0;
    update_vld();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int a0, b0, cyc;
    for (int i = 0; i < 3; i++) begin pkt_cnt[i] = 0; rd_cnt[i] = 0; end

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_outputs", {read_enb_0, read_enb_1, read_enb_2, egress_valid, egress_data,
                               egress_sop, egress_eop, egress_port, pkt_abort, egress_perr}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: fixed port-1 packet, ready high.
    rdy_mode = 1'b0;
    b0 = beat_cnt;
    rd_cnt[1] = 0;
    push_byte(1, 8'h0D); push_byte(1, 8'h11); push_byte(1, 8'h22);
    push_byte(1, 8'h33); push_byte(1, 8'h0D);
    pkt_cnt[1]++;
    plan();
    update_vld();
    drain(100);
    check_eq("t1_read_enb_1_cycles", rd_cnt[1], 5);
    check_eq("t1_beats", beat_cnt - b0, 5);

    // Test 5: same packet with a bad parity byte.
    push_byte(1, 8'h0D); push_byte(1, 8'h11); push_byte(1, 8'h22);
    push_byte(1, 8'h33); push_byte(1, 8'h0C);
    pkt_cnt[1]++;
    plan();
    update_vld();
    drain(100);

    // Test 2: one len=2 packet on every port after reset, then ports 0 and 1 again.
    do_reset("t2_reset_outputs");
    sop_q.delete();
    for (int p = 0; p < 3; p++) load_pkt(p, 2, 1'b0);
    plan();
    update_vld();
    drain(200);
    load_pkt(1, 2, 1'b0);
    load_pkt(0, 2, 1'b0);
    plan();
    update_vld();
    drain(200);
    check_eq("t2_order_len", sop_q.size(), 5);
    if (sop_q.size() == 5) begin
      check_eq("t2_first",  sop_q[0], 0);
      check_eq("t2_second", sop_q[1], 1);
      check_eq("t2_third",  sop_q[2], 2);
      check_eq("t2_next",   sop_q[3], 0);
    end

    // Test 3: 10 cycles of back-pressure in the middle of a len=20 packet.
    load_pkt(0, 20, 1'b0);
    plan();
    update_vld();
    repeat (6) tick();
    ready_low = 10;
    drain(300);

    // Test 4: port-2 packet runs dry mid-body; abort, then port 0 wins.
    sop_q.delete();
    a0 = abort_cnt;
    push_byte(2, 8'h2A);   // len 10, addr 2
    exp_q.push_back(mk_beat(2, 1'b1, 1'b0, 1'b0, 8'h2A));
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      push_byte(2, b);
      exp_q.push_back(mk_beat(2, 1'b0, 1'b0, 1'b0, b));
    end
    mq2.delete();
    update_vld();
    cyc = 0;
    while (abort_cnt == a0 && cyc < 100) begin
      if (cyc == 8) begin
        load_pkt(1, 3, 1'b0);
        load_pkt(0, 3, 1'b0);
        update_vld();
      end
      tick();
      cyc++;
    end
    check_eq("t4_abort_seen", abort_cnt - a0, 1);
    model_ptr = 0;
    plan();
    drain(300);
    check_eq("t4_abort_single", abort_cnt - a0, 1);
    check_eq("t4_sop_count", sop_q.size(), 3);
    if (sop_q.size() == 3) begin
      check_eq("t4_aborted_port", sop_q[0], 2);
      check_eq("t4_next_grant",   sop_q[1], 0);
    end

    // Test 6: async reset at beat 3 of a packet.
    load_pkt(1, 8, 1'b0);
    plan();
    update_vld();
    b0 = beat_cnt;
    cyc = 0;
    while (beat_cnt - b0 < 3 && cyc < 50) begin tick(); cyc++; end
    check_eq("t6_beats_before_reset", beat_cnt - b0, 3);
    do_reset("t6_reset_outputs");
    repeat (4) tick();
    sop_q.delete();
    load_pkt(2, 1, 1'b0);
    load_pkt(0, 1, 1'b0);
    plan();
    update_vld();
    drain(200);
    check_eq("t6_sop_count", sop_q.size(), 2);
    if (sop_q.size() == 2) check_eq("t6_first_after_reset", sop_q[0], 0);

    // Randomized rounds with random back-pressure and occasional bad parity.
    rdy_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 3; p++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          int len;
          len = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 12);
          load_pkt(p, len, ($urandom_range(0, 3) == 0));
        end
      end
      plan();
      update_vld();
      drain(5000);
    end
    rdy_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
